// File: rtl/serial_in_parallel_out_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_in_parallel_out_rx_if
// Brief    : SPI pin side and word handshake of the SPI receive deserializer.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_in_parallel_out_rx_if #(
    parameter int Size = 16
);
    logic [1:0]      SelectMode;
    logic            SCLK;
    logic            SS_n;
    logic            SDI;
    logic            Data_Read;
    logic [Size-1:0] Data_Out;
    logic            Data_Valid;
    logic            Overrun;
    logic            Frame_Error;
    logic            Busy;

    modport master (
        output SelectMode, SCLK, SS_n, SDI, Data_Read,
        input  Data_Out, Data_Valid, Overrun, Frame_Error, Busy
    );

    modport slave (
        input  SelectMode, SCLK, SS_n, SDI, Data_Read,
        output Data_Out, Data_Valid, Overrun, Frame_Error, Busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_in_parallel_out_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_in_parallel_out_rx
// Brief    : Oversampled SPI receive deserializer, LSB first, all SPI modes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out_rx #(
    parameter int Size        = 16,
    parameter int Sync_Stages = 2
) (
    input  logic CLK,
    input  logic Reset,
    serial_in_parallel_out_rx_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(Size + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(Size - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [Sync_Stages-1:0] r_sclk_sync;
    logic [Sync_Stages-1:0] r_ssn_sync;
    logic [Sync_Stages-1:0] r_sdi_sync;
    logic                   r_sclk_hist;
    logic [Size-1:0]        r_shift;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_done;
    logic [Size-1:0]        r_data_out;
    logic                   r_data_valid;
    logic                   r_overrun;
    logic                   r_frame_error;
    logic                   r_busy;

    logic w_sclk;
    logic w_ssn;
    logic w_sdi;
    logic w_sample;
    logic w_partial;

    // SDI is tapped at the same depth as SCLK so data and clock stay aligned
    assign w_sclk = r_sclk_sync[Sync_Stages-1];
    assign w_ssn  = r_ssn_sync[Sync_Stages-1];
    assign w_sdi  = r_sdi_sync[Sync_Stages-1];

    // Modes 0/3 sample on the rising edge, modes 1/2 on the falling edge
    assign w_sample  = (w_sclk ^ r_sclk_hist) &
                       (w_sclk != (bus.SelectMode[1] ^ bus.SelectMode[0]));
    assign w_partial = w_sample ? (r_count != c_last) : (r_count != '0);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_sclk_sync   <= {Sync_Stages{bus.SelectMode[1]}};
            r_ssn_sync    <= '1;
            r_sdi_sync    <= '0;
            r_sclk_hist   <= bus.SelectMode[1];
            r_shift       <= '0;
            r_count       <= '0;
            r_done        <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[Sync_Stages-2:0], bus.SCLK};
            r_ssn_sync    <= {r_ssn_sync[Sync_Stages-2:0], bus.SS_n};
            r_sdi_sync    <= {r_sdi_sync[Sync_Stages-2:0], bus.SDI};
            r_sclk_hist   <= w_sclk;
            r_done        <= 1'b0;
            r_frame_error <= 1'b0;

            // A read in the completion cycle acknowledges any earlier overrun
            if (r_done) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                if (r_data_valid) begin
                    r_overrun <= !bus.Data_Read;
                end
            end else if (bus.Data_Read && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_ssn) begin
                        r_state <= ST_RECEIVE;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_shift <= '0;
                    end
                end
                ST_RECEIVE: begin
                    if (w_sample) begin
                        r_shift <= {w_sdi, r_shift[Size-1:1]};
                        if (r_count == c_last) begin
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                    // A final sample edge coinciding with deselect still completes
                    if (w_ssn) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_count       <= '0;
                        r_frame_error <= w_partial;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Data_Out    = r_data_out;
    assign bus.Data_Valid  = r_data_valid;
    assign bus.Overrun     = r_overrun;
    assign bus.Frame_Error = r_frame_error;
    assign bus.Busy        = r_busy;

endmodule
`default_nettype wire
